// File: rtl/responder_ctrl_if.sv
// Bus interface for responder_ctrl (quiz-show first-responder controller).
//   slave  : controller side (takes host/key/endtime, drives timer, winner, buzzer)
//   master : host/bench side
// Inputs : host_start, host_clear, key[N_KEYS], endtime
// Outputs: starttimer, stoptime, winner_oh, winner_id, winner_valid, foul, timeout, buzz
interface responder_ctrl_if #(
  parameter int N_KEYS = 4,
  parameter int ID_W   = $clog2(N_KEYS)
);
  logic              host_start;
  logic              host_clear;
  logic [N_KEYS-1:0] key;
  logic              endtime;
  logic              starttimer;
  logic              stoptime;
  logic [N_KEYS-1:0] winner_oh;
  logic [ID_W-1:0]   winner_id;
  logic              winner_valid;
  logic [N_KEYS-1:0] foul;
  logic              timeout;
  logic              buzz;

  modport slave (
    input  host_start, host_clear, key, endtime,
    output starttimer, stoptime, winner_oh, winner_id, winner_valid, foul, timeout, buzz
  );

  modport master (
    output host_start, host_clear, key, endtime,
    input  starttimer, stoptime, winner_oh, winner_id, winner_valid, foul, timeout, buzz
  );
endinterface

// File: rtl/responder_ctrl.sv
// responder_ctrl: first-responder controller for a quiz buzzer.
//   clk, rst_n : system clock (rising edge), asynchronous active-low reset
//   bus        : responder_ctrl_if.slave -- host keys, contestant keys, timer
//                handshake (endtime/starttimer/stoptime), winner, foul, timeout, buzz
// Parameters: N_KEYS (2..8), BUZZ_CYCLES (buzzer pulse length), ARM_GUARD
//   (cycles after arming during which endtime is ignored).
// Optional feature: define RESP_FOUL_EN to flag keys pressed while idle and
//   bar them from winning the next round; otherwise foul is constant 0.

// Two-flop synchroniser plus rising-edge detector for one asynchronous bit.
module responder_sync (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic rise
);
  logic s1, s2, s3;

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) {s1, s2, s3} <= 3'b000;
    else        {s1, s2, s3} <= {d, s1, s2};

  assign rise = s2 & ~s3;
endmodule

module responder_ctrl #(
  parameter int N_KEYS      = 4,
  parameter int BUZZ_CYCLES = 25000000,
  parameter int ARM_GUARD   = 2
) (
  input  logic            clk,
  input  logic            rst_n,
  responder_ctrl_if.slave bus
);
  localparam int ID_W        = $clog2(N_KEYS);
  localparam int NS          = N_KEYS + 2;
  localparam int SYNC_STAGES = 2;
  localparam int GW = (ARM_GUARD > 0)   ? $clog2(ARM_GUARD + 1)   : 1;
  localparam int BW = (BUZZ_CYCLES > 0) ? $clog2(BUZZ_CYCLES + 1) : 1;

  typedef enum logic [1:0] {IDLE, ARMED, LOCKED, TIMEOUT} state_e;
  state_e state, state_nxt;

  logic [NS-1:0]          raw, rise;
  logic [SYNC_STAGES:0]   vld_pipe;
  logic [N_KEYS-1:0]      key_ev, qual, win_oh, foul_q;
  logic                   start_ev, clear_ev, lock, tmo, guard_done;
  logic [ID_W-1:0]        win_id;
  logic [GW-1:0]          guard_cnt;
  logic [BW-1:0]          buzz_cnt;
  logic                   stoptime_q, winner_valid_q, timeout_q, buzz_q;
  logic [N_KEYS-1:0]      winner_oh_q;
  logic [ID_W-1:0]        winner_id_q;

  // Bit order: keys, then host_start, then host_clear.
  assign raw = {bus.host_clear, bus.host_start, bus.key};

  for (genvar i = 0; i < NS; i++) begin : g_sync
    responder_sync u_sync (.clk(clk), .rst_n(rst_n), .d(raw[i]), .rise(rise[i]));
  end

  // Edge detection is only trusted once the whole chain holds post-reset
  // samples; without this, a key held across reset would look like a fresh press.
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) vld_pipe <= '0;
    else        vld_pipe <= {vld_pipe[SYNC_STAGES-1:0], 1'b1};

  assign key_ev   = rise[N_KEYS-1:0] & {N_KEYS{vld_pipe[SYNC_STAGES]}};
  assign start_ev = rise[N_KEYS]     & vld_pipe[SYNC_STAGES];
  assign clear_ev = rise[N_KEYS+1]   & vld_pipe[SYNC_STAGES];

  assign guard_done = (guard_cnt == GW'(ARM_GUARD));
  assign qual       = key_ev & ~foul_q;

  // Lowest-index qualifying key wins simultaneous presses.
  always_comb begin
    win_oh = '0;
    win_id = '0;
    for (int i = N_KEYS - 1; i >= 0; i--)
      if (qual[i]) begin
        win_oh = N_KEYS'(1) << i;
        win_id = ID_W'(i);
      end
  end

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;

  always_comb begin
    state_nxt = state;
    lock      = 1'b0;
    tmo       = 1'b0;
    case (state)
      IDLE:  if (start_ev) state_nxt = ARMED;
      ARMED: begin
        // A key press in the same cycle as endtime still locks the round.
        if (|qual) begin
          state_nxt = LOCKED;
          lock      = 1'b1;
        end else if (bus.endtime && guard_done) begin
          state_nxt = TIMEOUT;
          tmo       = 1'b1;
        end
      end
      default: state_nxt = state;
    endcase
    if (clear_ev) begin
      state_nxt = IDLE;
      lock      = 1'b0;
      tmo       = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n)                guard_cnt <= '0;
    else if (state != ARMED)   guard_cnt <= '0;
    else if (!guard_done)      guard_cnt <= guard_cnt + 1'b1;

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      stoptime_q     <= 1'b0;
      winner_oh_q    <= '0;
      winner_id_q    <= '0;
      winner_valid_q <= 1'b0;
      timeout_q      <= 1'b0;
      buzz_q         <= 1'b0;
      buzz_cnt       <= '0;
    end else if (clear_ev) begin
      stoptime_q     <= 1'b0;
      winner_oh_q    <= '0;
      winner_id_q    <= '0;
      winner_valid_q <= 1'b0;
      timeout_q      <= 1'b0;
      buzz_q         <= 1'b0;
      buzz_cnt       <= '0;
    end else begin
      stoptime_q <= lock;
      if (lock) begin
        winner_oh_q    <= win_oh;
        winner_id_q    <= win_id;
        winner_valid_q <= 1'b1;
      end
      if (tmo) timeout_q <= 1'b1;
      // Counter is loaded on entry; buzz rises one cycle later and stays
      // high for exactly BUZZ_CYCLES cycles.
      if (lock || tmo) begin
        buzz_cnt <= BW'(BUZZ_CYCLES);
        buzz_q   <= 1'b0;
      end else if (buzz_cnt != '0) begin
        buzz_cnt <= buzz_cnt - 1'b1;
        buzz_q   <= 1'b1;
      end else begin
        buzz_q   <= 1'b0;
      end
    end

`ifdef RESP_FOUL_EN
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n)              foul_q <= '0;
    else if (clear_ev)       foul_q <= '0;
    else if (state == IDLE)  foul_q <= foul_q | key_ev;
`else
  assign foul_q = '0;
`endif

  assign bus.starttimer   = (state == ARMED);
  assign bus.stoptime     = stoptime_q;
  assign bus.winner_oh    = winner_oh_q;
  assign bus.winner_id    = winner_id_q;
  assign bus.winner_valid = winner_valid_q;
  assign bus.foul         = foul_q;
  assign bus.timeout      = timeout_q;
  assign bus.buzz         = buzz_q;
endmodule

// File: doc/responder_ctrl.md
RESPONDER_CTRL -- requirements
Module: responder_ctrl

Interface
REQ-001 SHALL have parameter N_KEYS, default 4: number of contestant keys, legal range 2..8.
REQ-002 SHALL have parameter BUZZ_CYCLES, default 25000000: buzzer pulse length in clk cycles.
REQ-003 SHALL have parameter ARM_GUARD, default 2: clk cycles after entering ARMED during which endtime is ignored.
REQ-004 SHALL have port clk, input, 1: single system clock; all logic on its rising edge.
REQ-005 SHALL have port rst_n, input, 1: asynchronous active-low reset.
REQ-006 SHALL have port host_start, input, 1: host start key, asynchronous, level.
REQ-007 SHALL have port host_clear, input, 1: host clear key, asynchronous, level.
REQ-008 SHALL have port key, input, N_KEYS: contestant keys, asynchronous, active-high.
REQ-009 SHALL have port endtime, input, 1: countdown-expired flag from the timer stage.
REQ-010 SHALL have port starttimer, output, 1: timer run enable; low holds the timer reloaded to maxtime.
REQ-011 SHALL have port stoptime, output, 1: one-cycle timer reload pulse.
REQ-012 SHALL have port winner_oh, output, N_KEYS: one-hot winner indicator.
REQ-013 SHALL have port winner_id, output, ceil(log2(N_KEYS)): binary winner index.
REQ-014 SHALL have port winner_valid, output, 1: winner_oh and winner_id are meaningful.
REQ-015 SHALL have port foul, output, N_KEYS: per-key early-press flags.
REQ-016 SHALL have port timeout, output, 1: round ended with no answer.
REQ-017 SHALL have port buzz, output, 1: buzzer drive.

Function
REQ-018 SHALL synchronise host_start, host_clear and every key bit through two flops, then rising-edge detect them; only the detected edges are events.
REQ-019 SHALL implement states IDLE, ARMED, LOCKED and TIMEOUT.
REQ-020 SHALL, on a host_clear edge in any state, go to IDLE and clear winner_valid, winner_oh, winner_id, foul, timeout and buzz; host_clear has priority over every other event in the same cycle.
REQ-021 SHALL, on a host_start edge in IDLE, go to ARMED; host_start SHALL be ignored in every other state.
REQ-022 SHALL assert starttimer exactly while in ARMED.
REQ-023 SHALL, in ARMED, on one or more key edges from non-fouled keys, go to LOCKED, latching the lowest-index such key into winner_oh/winner_id and setting winner_valid.
REQ-024 SHALL pulse stoptime for exactly one cycle on the ARMED->LOCKED transition.
REQ-025 SHALL, in ARMED, once ARM_GUARD cycles have elapsed, go to TIMEOUT and set timeout when endtime is 1.
REQ-026 SHALL give a qualifying key edge priority over endtime when both occur in the same cycle, so that the round locks.
REQ-027 SHALL ignore all key edges in LOCKED and TIMEOUT; outputs SHALL hold until host_clear.
REQ-028 SHALL assert buzz for exactly BUZZ_CYCLES cycles starting the cycle after entering LOCKED or TIMEOUT; host_clear SHALL abort the pulse.
REQ-029 SHALL have a latency of 3 clk cycles from a raw key rising edge to winner_valid (2 sync + 1 register).

Reset
REQ-030 SHALL, while rst_n is 0, immediately force state IDLE, all synchroniser flops 0, starttimer 0, stoptime 0, winner_oh 0, winner_id 0, winner_valid 0, foul 0, timeout 0, buzz 0, and the guard and buzz counters 0.
REQ-031 SHALL, when reset is asserted mid-round, discard the round; after release no event SHALL be detected from keys already held high.

Configuration
REQ-032 SHALL support macro RESP_FOUL_EN: when defined, a key edge in IDLE sets that key's foul bit, and fouled keys cannot win the following round until host_clear.
REQ-033 SHALL, when RESP_FOUL_EN is undefined, hold foul at constant 0 and ignore key edges in IDLE.

Verification
REQ-034 SHALL cover: reset, host_start, then key[2] edge -> LOCKED, winner_id=2, winner_oh=4'b0100, winner_valid=1, one stoptime pulse, starttimer=0.
REQ-035 SHALL cover: ARMED, key[3] and key[1] rising in the same cycle -> winner_id=1.
REQ-036 SHALL cover: ARMED, no keys, endtime=1 after guard -> timeout=1, buzz high for exactly BUZZ_CYCLES (test value 8), starttimer=0.
REQ-037 SHALL cover: key[0] edge and endtime in the same cycle -> LOCKED, winner_id=0, timeout=0.
REQ-038 SHALL cover (RESP_FOUL_EN defined): key[1] pressed in IDLE -> foul=4'b0010; then host_start, key[1] then key[3] -> winner_id=3.
REQ-039 SHALL cover: host_clear mid-buzz, and rst_n low in ARMED -> all outputs 0, state IDLE, buzz ends immediately.
